counter_event_monitor: RTL and testbench

- Sits directly downstream of the 4-bit enable-gated up-counter. Samples the counter output every clock.
- Extends the count with a wrap counter and detects wrap, restart, jump and compare-match events.
- Queues one event record per cycle into a small FIFO, drained by a valid/ready consumer (bench checker or debug logger).

---
 rtl/counter_mon_pkg.sv | 25 ++
 rtl/mon_event_fifo.sv | 50 +++++
 rtl/counter_event_monitor.sv | 129 ++++++++++++
 tb/tb_counter_event_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_mon_pkg.sv
// Shared event codes, FSM encodings and record sizing for the counter event monitor.
// COUNTER_MON_TIMESTAMP_EN widens each event record with a 16-bit timestamp prefix.
package counter_mon_pkg;

  typedef enum logic [1:0] {
    EVT_WRAP    = 2'b00,
    EVT_MATCH   = 2'b01,
    EVT_RESTART = 2'b10,
    EVT_JUMP    = 2'b11
  } evt_type_e;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_TRACK = 1'b1
  } state_e;

  localparam int TS_W = 16;

`ifdef COUNTER_MON_TIMESTAMP_EN
  localparam int TS_BITS = TS_W;
`else
  localparam int TS_BITS = 0;
`endif

endpackage

// File: rtl/mon_event_fifo.sv
// Synchronous event FIFO with valid/ready drain; a push into a full FIFO is
// still accepted when the head is popped in the same cycle.
module mon_event_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop;
  logic             accept;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign valid  = (wr_ptr != rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = valid && ready;
  assign accept = push && (!full || pop);
  assign data   = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/counter_event_monitor.sv
// Watches a 4-bit up-counter, extends it with a wrap count and queues wrap/restart/jump/match
// records for a valid/ready consumer. COUNTER_MON_TIMESTAMP_EN prefixes records with a cycle timestamp.
module counter_event_monitor
  import counter_mon_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int WRAP_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              enable,
  input  logic [CNT_W-1:0]                  counter_in,
  input  logic [CNT_W-1:0]                  match_value,
  output logic [WRAP_W+CNT_W-1:0]           ext_count,
  output logic                              wrap_pulse,
  output logic                              match_pulse,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [TS_BITS+2+WRAP_W+CNT_W-1:0] evt_data,
  output logic                              evt_overflow
);

  localparam int REC_W = TS_BITS + 2 + WRAP_W + CNT_W;
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_e            state;
  logic [CNT_W-1:0]  prev;
  logic [CNT_W-1:0]  prev_inc;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [WRAP_W-1:0] wrap_next;
  logic              tracking;
  logic              changed;
  logic              is_wrap;
  logic              is_restart;
  logic              is_jump;
  logic              is_match;
  logic              push;
  logic              dropped;
  logic              fifo_full;
  evt_type_e         evt_type;
  logic [REC_W-1:0]  rec;

  // enable only qualifies the upstream counter; changes while it is low surface as jumps.
  logic unused_enable;
  assign unused_enable = enable;

  assign prev_inc = prev + 1'b1;

  always_comb begin
    tracking   = (state == S_TRACK);
    changed    = (counter_in != prev);
    is_wrap    = tracking && (prev == ALL_ONES) && (counter_in == '0);
    is_restart = tracking && (counter_in == '0) && (prev != ALL_ONES) && (prev != '0);
    is_jump    = tracking && changed && (counter_in != prev_inc) && !is_wrap && !is_restart;
    is_match   = tracking && changed && (counter_in == match_value);
    wrap_next  = is_wrap ? wrap_cnt + 1'b1 : wrap_cnt;
    evt_type   = EVT_MATCH;
    if (is_jump)    evt_type = EVT_JUMP;
    if (is_restart) evt_type = EVT_RESTART;
    if (is_wrap)    evt_type = EVT_WRAP;
  end

  assign push    = !clear && (is_wrap || is_restart || is_jump || is_match);
  assign dropped = push && fifo_full && !(evt_valid && evt_ready);

`ifdef COUNTER_MON_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     ts <= '0;
    else if (clear) ts <= '0;
    else            ts <= ts + 1'b1;
  end

  assign rec = {ts, evt_type, wrap_next, counter_in};
`else
  assign rec = {evt_type, wrap_next, counter_in};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_INIT;
      prev         <= '0;
      wrap_cnt     <= '0;
      ext_count    <= '0;
      wrap_pulse   <= 1'b0;
      match_pulse  <= 1'b0;
      evt_overflow <= 1'b0;
    end else if (clear) begin
      state        <= S_INIT;
      prev         <= '0;
      wrap_cnt     <= '0;
      ext_count    <= {{WRAP_W{1'b0}}, counter_in};
      wrap_pulse   <= 1'b0;
      match_pulse  <= 1'b0;
      evt_overflow <= 1'b0;
    end else begin
      case (state)
        S_INIT:  state <= S_TRACK;
        S_TRACK: state <= S_TRACK;
        default: state <= S_INIT;
      endcase
      prev        <= counter_in;
      wrap_cnt    <= wrap_next;
      ext_count   <= {wrap_next, counter_in};
      wrap_pulse  <= is_wrap;
      match_pulse <= is_match;
      if (dropped) evt_overflow <= 1'b1;
    end
  end

  mon_event_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .push_data (rec),
    .valid     (evt_valid),
    .ready     (evt_ready),
    .data      (evt_data),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_counter_event_monitor.sv
// Directed and randomized bench for counter_event_monitor against a queue-based reference model.
module tb_counter_event_monitor;
  import counter_mon_pkg::*;

  localparam int CNT_W  = 4;
  localparam int WRAP_W = 12;
  localparam int DEPTH  = 4;
  localparam int EVT_W  = TS_BITS + 2 + WRAP_W + CNT_W;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    clear = 1'b0;
  logic                    enable = 1'b0;
  logic                    evt_ready = 1'b0;
  logic [CNT_W-1:0]        counter_in = '0;
  logic [CNT_W-1:0]        match_value = '0;
  logic [WRAP_W+CNT_W-1:0] ext_count;
  logic                    wrap_pulse;
  logic                    match_pulse;
  logic                    evt_valid;
  logic                    evt_overflow;
  logic [EVT_W-1:0]        evt_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit               m_have;
  int               m_prev;
  int               m_wraps;
  int               m_ts;
  int               m_ext;
  bit               m_ovf;
  bit               m_wp;
  bit               m_mp;
  logic [EVT_W-1:0] m_q[$];

  counter_event_monitor #(
    .CNT_W      (CNT_W),
    .WRAP_W     (WRAP_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .enable       (enable),
    .counter_in   (counter_in),
    .match_value  (match_value),
    .ext_count    (ext_count),
    .wrap_pulse   (wrap_pulse),
    .match_pulse  (match_pulse),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .evt_overflow (evt_overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have  = 1'b0;
    m_prev  = 0;
    m_wraps = 0;
    m_ts    = 0;
    m_ext   = 0;
    m_ovf   = 1'b0;
    m_wp    = 1'b0;
    m_mp    = 1'b0;
    m_q.delete();
  endtask

  // Advances the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    int cur;
    int mv;
    int ty;
    bit push;
    bit pop;
    bit full;
    logic [EVT_W-1:0] rec;
    cur = int'(counter_in);
    mv  = int'(match_value);
    if (clear) begin
      model_reset();
      m_ext = cur;
      return;
    end
    push = 1'b0;
    ty   = 0;
    m_wp = 1'b0;
    m_mp = 1'b0;
    if (m_have && cur != m_prev) begin
      m_mp = (cur == mv);
      if (m_prev == 15 && cur == 0) begin
        ty = 0; m_wraps = (m_wraps + 1) % 4096; m_wp = 1'b1; push = 1'b1;
      end else if (cur == 0) begin
        ty = 2; push = 1'b1;
      end else if (cur != (m_prev + 1) % 16) begin
        ty = 3; push = 1'b1;
      end else if (m_mp) begin
        ty = 1; push = 1'b1;
      end
    end
    rec  = EVT_W'({m_ts[15:0], ty[1:0], m_wraps[11:0], cur[3:0]});
    full = (m_q.size() == DEPTH);
    pop  = (m_q.size() > 0) && evt_ready;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!full || pop) m_q.push_back(rec);
      else m_ovf = 1'b1;
    end
    m_ext  = m_wraps * 16 + cur;
    m_have = 1'b1;
    m_prev = cur;
    m_ts   = (m_ts + 1) % 65536;
  endtask

  task automatic check_outputs(input string tag);
    logic [EVT_W-1:0] ed;
    ed = '0;
    if (m_q.size() > 0) ed = m_q[0];
    chk({tag, ".evt_valid"},    64'(evt_valid),    64'(m_q.size() > 0));
    chk({tag, ".evt_data"},     64'(evt_data),     64'(ed));
    chk({tag, ".wrap_pulse"},   64'(wrap_pulse),   64'(m_wp));
    chk({tag, ".match_pulse"},  64'(match_pulse),  64'(m_mp));
    chk({tag, ".ext_count"},    64'(ext_count),    64'(m_ext));
    chk({tag, ".evt_overflow"}, 64'(evt_overflow), 64'(m_ovf));
  endtask

  // Called at a falling edge: drive, model the coming rising edge, sample at the next falling edge.
  task automatic step(input int cnt, input bit rdy, input string tag);
    counter_in = CNT_W'(cnt);
    evt_ready  = rdy;
    model_edge();
    @(posedge clock);
    @(negedge clock);
    check_outputs(tag);
  endtask

  task automatic do_clear(input int cnt);
    clear = 1'b1;
    step(cnt, 1'b0, "clear");
    clear = 1'b0;
  endtask

  initial begin
    int rc;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs("reset");

    // Basic counting through a wrap with match on F
    reset = 1'b1;
    enable = 1'b1;
    match_value = 4'hF;
    for (int i = 0; i < 16; i++) step(i, 1'b1, "count");
    chk("match_rec", 64'(evt_data[17:0]), 64'h1000F);
    chk("match_pulse_f", 64'(match_pulse), 64'h1);
    step(0, 1'b1, "wrap");
    chk("wrap_rec", 64'(evt_data[17:0]), 64'h00010);
    chk("wrap_pulse_0", 64'(wrap_pulse), 64'h1);
    chk("ext_after_wrap", 64'(ext_count), 64'h0010);
    step(1, 1'b1, "post_wrap");
    chk("wrap_pulse_1cyc", 64'(wrap_pulse), 64'h0);

    // Upstream restart from 7
    for (int i = 2; i < 8; i++) step(i, 1'b1, "to7");
    step(0, 1'b1, "restart");
    chk("restart_type", 64'(evt_data[17:16]), 64'h2);
    chk("restart_wraps", 64'(evt_data[15:4]), 64'h1);
    chk("restart_no_wrap_pulse", 64'(wrap_pulse), 64'h0);
    chk("restart_ext", 64'(ext_count), 64'h0010);

    // Overflow: five matches with the consumer stalled
    for (int i = 1; i <= 5; i++) begin
      match_value = CNT_W'(i);
      step(i, 1'b0, "fill");
    end
    chk("overflow_set", 64'(evt_overflow), 64'h1);
    for (int i = 0; i < 4; i++) step(5, 1'b1, "drain");
    chk("drained_empty", 64'(evt_valid), 64'h0);
    do_clear(5);
    chk("overflow_cleared", 64'(evt_overflow), 64'h0);

    // Full FIFO with simultaneous pop and push
    step(5, 1'b0, "init5");
    for (int i = 6; i <= 9; i++) begin
      match_value = CNT_W'(i);
      step(i, 1'b0, "fill4");
    end
    match_value = 4'hA;
    step(10, 1'b1, "full_push_pop");
    chk("full_pp_no_ovf", 64'(evt_overflow), 64'h0);
    step(10, 1'b0, "hold");
    for (int i = 0; i < 4; i++) step(10, 1'b1, "drain4");
    chk("drain4_empty", 64'(evt_valid), 64'h0);

    // Wrap coinciding with match on 0
    do_clear(0);
    match_value = 4'h0;
    for (int i = 0; i < 16; i++) step(i, 1'b1, "count2");
    step(0, 1'b1, "wrap_match");
    chk("wm_wrap_pulse", 64'(wrap_pulse), 64'h1);
    chk("wm_match_pulse", 64'(match_pulse), 64'h1);
    chk("wm_type", 64'(evt_data[17:16]), 64'h0);
    step(1, 1'b1, "wm_after");
    chk("wm_single_record", 64'(evt_valid), 64'h0);

    // Randomized traffic
    rc = 1;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 70)      rc = (rc + 1) % 16;
      else if (r < 80) rc = rc;
      else if (r < 88) rc = 0;
      else             rc = int'($urandom_range(0, 15));
      match_value = CNT_W'($urandom_range(0, 15));
      enable = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 99) < 2);
      step(rc, ($urandom_range(0, 99) < 60), "rand");
      clear = 1'b0;
    end

    // Asynchronous reset with three queued entries
    enable = 1'b1;
    do_clear(2);
    step(2, 1'b0, "ar_init");
    for (int i = 3; i <= 5; i++) begin
      match_value = CNT_W'(i);
      step(i, 1'b0, "ar_fill");
    end
    chk("ar_queued", 64'(evt_valid), 64'h1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("ar_valid", 64'(evt_valid), 64'h0);
    chk("ar_match_pulse", 64'(match_pulse), 64'h0);
    chk("ar_wrap_pulse", 64'(wrap_pulse), 64'h0);
    chk("ar_ext", 64'(ext_count), 64'h0);
    chk("ar_data", 64'(evt_data), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    step(9, 1'b1, "ar_first");
    chk("ar_first_no_event", 64'(evt_valid), 64'h0);
    step(3, 1'b1, "ar_second");
    chk("ar_second_jump", 64'(evt_data[17:16]), 64'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
